// File: rtl/inference_scheduler_pkg.sv
// Shared state encoding and timing constants for the classification-pass sequencer.
// Also holds the helper that sizes the shared phase counter.
package inference_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CLEAR     = 3'd1,
    ST_INTEGRATE = 3'd2,
    ST_LEAK      = 3'd3,
    ST_TX_REQ    = 3'd4,
    ST_TX_WAIT   = 3'd5,
    ST_DONE      = 3'd6
  } state_t;

  // The argmax scan finishes ARGMAX_LAT cycles after the leak rise, so the
  // leak window needs one more cycle before the class can be latched.
  localparam int ARGMAX_LAT      = 11;
  localparam int MIN_LEAK_CYCLES = ARGMAX_LAT + 1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic int phase_width(input int step_cycles, input int leak_cycles,
                                     input int tx_timeout);
    return $clog2(max3(step_cycles, leak_cycles, tx_timeout) + 1);
  endfunction

endpackage

// File: rtl/inference_scheduler_phase_timer.sv
// Loadable down-counter shared by the integrate, leak and transfer-wait phases.
// expired is high whenever the count has reached zero; the count parks at zero.
module phase_timer #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST_sync,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge CLK) begin
    if (RST_sync) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/inference_scheduler.sv
// Sequencer for one spike-count classification pass: clear, integrate/leak per
// timestep, latch the argmax class, then request and supervise one UDP transfer.
module inference_scheduler
  import inference_scheduler_pkg::*;
#(
  parameter int NUM_STEPS   = 16,
  parameter int STEP_CYCLES = 1000,
  parameter int LEAK_CYCLES = 12,
  parameter int TX_TIMEOUT  = 65535
) (
  input  logic       CLK,
  input  logic       RST_sync,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] result_num,
  input  logic       udp_tx_done_source,
  output logic       Memory_CLK,
  output logic       global_leak_time,
  output logic       tx_start,
  output logic [3:0] result,
  output logic       result_valid,
  output logic       tx_err,
  output logic       done,
  output logic       busy,
  output logic [7:0] step_idx
);

  localparam int PHASE_W = phase_width(STEP_CYCLES, LEAK_CYCLES, TX_TIMEOUT);

  // Timer load values are one less than the phase length because the phase
  // ends in the cycle where the count reads zero.
  localparam logic [PHASE_W-1:0] STEP_LOAD = PHASE_W'(STEP_CYCLES - 1);
  localparam logic [PHASE_W-1:0] LEAK_LOAD = PHASE_W'(LEAK_CYCLES - 1);
  localparam logic [PHASE_W-1:0] TX_LOAD   = PHASE_W'(TX_TIMEOUT - 1);
  localparam logic [7:0]         LAST_STEP = 8'(NUM_STEPS - 1);

  if (LEAK_CYCLES < MIN_LEAK_CYCLES) begin : g_leak_check
    $error("LEAK_CYCLES is shorter than the argmax scan latency plus one");
  end
  if (NUM_STEPS < 1 || NUM_STEPS > 255) begin : g_steps_check
    $error("NUM_STEPS must lie in 1..255");
  end
  if (STEP_CYCLES < 1 || STEP_CYCLES > 65535 || TX_TIMEOUT < 1) begin : g_cycles_check
    $error("STEP_CYCLES must lie in 1..65535 and TX_TIMEOUT must be at least 1");
  end

  state_t             state;
  logic               abort_hit;
  logic               more_steps;
  logic               timer_load;
  logic [PHASE_W-1:0] timer_value;
  logic               timer_expired;

  assign abort_hit  = abort && (state != ST_IDLE);
  assign more_steps = (step_idx < LAST_STEP);

  phase_timer #(
    .WIDTH(PHASE_W)
  ) u_phase_timer (
    .CLK       (CLK),
    .RST_sync  (RST_sync),
    .load      (timer_load),
    .load_value(timer_value),
    .expired   (timer_expired)
  );

  // Reload the shared timer on the edge that enters each timed phase; an abort
  // parks it at zero so the next sample starts from a clean count.
  always_comb begin
    timer_load  = 1'b0;
    timer_value = '0;
    if (abort_hit) begin
      timer_load = 1'b1;
    end else begin
      case (state)
        ST_CLEAR: begin
          timer_load  = 1'b1;
          timer_value = STEP_LOAD;
        end
        ST_INTEGRATE: begin
          if (timer_expired) begin
            timer_load  = 1'b1;
            timer_value = LEAK_LOAD;
          end
        end
        ST_LEAK: begin
          if (timer_expired && more_steps) begin
            timer_load  = 1'b1;
            timer_value = STEP_LOAD;
          end
        end
        ST_TX_REQ: begin
          timer_load  = 1'b1;
          timer_value = TX_LOAD;
        end
        default: begin
          timer_load  = 1'b0;
          timer_value = '0;
        end
      endcase
    end
  end

  // Outputs are registered against the state being entered, so each pulse
  // lines up exactly with the cycle its state occupies.
  always_ff @(posedge CLK) begin
    if (RST_sync) begin
      state            <= ST_IDLE;
      Memory_CLK       <= 1'b0;
      global_leak_time <= 1'b0;
      tx_start         <= 1'b0;
      result           <= 4'd0;
      result_valid     <= 1'b0;
      tx_err           <= 1'b0;
      done             <= 1'b0;
      busy             <= 1'b0;
      step_idx         <= 8'd0;
    end else begin
      Memory_CLK <= 1'b0;
      tx_start   <= 1'b0;
      done       <= 1'b0;
      if (abort_hit) begin
        state            <= ST_IDLE;
        global_leak_time <= 1'b0;
        result_valid     <= 1'b0;
        busy             <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state        <= ST_CLEAR;
              Memory_CLK   <= 1'b1;
              busy         <= 1'b1;
              result_valid <= 1'b0;
              tx_err       <= 1'b0;
              step_idx     <= 8'd0;
            end
          end
          ST_CLEAR: begin
            state <= ST_INTEGRATE;
          end
          ST_INTEGRATE: begin
            if (timer_expired) begin
              state            <= ST_LEAK;
              global_leak_time <= 1'b1;
            end
          end
          ST_LEAK: begin
            if (timer_expired) begin
              global_leak_time <= 1'b0;
              if (more_steps) begin
                state    <= ST_INTEGRATE;
                step_idx <= step_idx + 8'd1;
              end else begin
                state        <= ST_TX_REQ;
                result       <= result_num;
                result_valid <= 1'b1;
                tx_start     <= 1'b1;
              end
            end
          end
          ST_TX_REQ: begin
            state <= ST_TX_WAIT;
          end
          ST_TX_WAIT: begin
            if (udp_tx_done_source) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else if (timer_expired) begin
              state  <= ST_DONE;
              done   <= 1'b1;
              tx_err <= 1'b1;
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inference_scheduler.sv
// Scoreboard bench: expected output events are queued as each sample is issued
// and a negedge monitor pops and compares them as the DUTs produce pulses.
`timescale 1ns/1ps
module tb_inference_scheduler;

  typedef enum int {EV_MEM, EV_RISE, EV_FALL, EV_TX, EV_DONE} ev_kind_t;

  typedef struct {
    ev_kind_t   kind;
    int         cycle;
    logic [3:0] result;
    logic       result_valid;
    logic       tx_err;
    logic [7:0] step_idx;
    logic       check_result;
  } exp_t;

  localparam int PERIOD_CYC = 4 + 12;

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc_now  = 0;
  int   base_a   = 0;
  int   base_b   = 0;
  logic mon_en   = 1'b0;
  logic prev_glt_a = 1'b0;
  logic prev_glt_b = 1'b0;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc_now = cyc_now + 1;

  logic       rst_a = 1'b1, start_a = 1'b0, abort_a = 1'b0, udp_done_a = 1'b0;
  logic [3:0] result_num_a = 4'd0;
  logic       mem_clk_a, glt_a, tx_start_a, rv_a, err_a, done_a, busy_a;
  logic [3:0] result_a;
  logic [7:0] step_a;

  logic       rst_b = 1'b1, start_b = 1'b0, abort_b = 1'b0, udp_done_b = 1'b0;
  logic [3:0] result_num_b = 4'd0;
  logic       mem_clk_b, glt_b, tx_start_b, rv_b, err_b, done_b, busy_b;
  logic [3:0] result_b;
  logic [7:0] step_b;

  inference_scheduler #(
    .NUM_STEPS(2), .STEP_CYCLES(4), .LEAK_CYCLES(12), .TX_TIMEOUT(20)
  ) dut_a (
    .CLK(CLK), .RST_sync(rst_a), .start(start_a), .abort(abort_a),
    .result_num(result_num_a), .udp_tx_done_source(udp_done_a),
    .Memory_CLK(mem_clk_a), .global_leak_time(glt_a), .tx_start(tx_start_a),
    .result(result_a), .result_valid(rv_a), .tx_err(err_a), .done(done_a),
    .busy(busy_a), .step_idx(step_a)
  );

  inference_scheduler #(
    .NUM_STEPS(1), .STEP_CYCLES(4), .LEAK_CYCLES(12), .TX_TIMEOUT(20)
  ) dut_b (
    .CLK(CLK), .RST_sync(rst_b), .start(start_b), .abort(abort_b),
    .result_num(result_num_b), .udp_tx_done_source(udp_done_b),
    .Memory_CLK(mem_clk_b), .global_leak_time(glt_b), .tx_start(tx_start_b),
    .result(result_b), .result_valid(rv_b), .tx_err(err_b), .done(done_b),
    .busy(busy_b), .step_idx(step_b)
  );

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic push_exp(input int which, input ev_kind_t kind, input int cycle,
                          input logic [3:0] res, input logic rv, input logic err,
                          input logic [7:0] step, input logic chk_res);
    exp_t e;
    e.kind = kind; e.cycle = cycle; e.result = res; e.result_valid = rv;
    e.tx_err = err; e.step_idx = step; e.check_result = chk_res;
    if (which == 0) q_a.push_back(e);
    else q_b.push_back(e);
  endtask

  // Expected event stream of a complete sample, timed from the spec timeline.
  task automatic push_run(input int which, input int n_steps, input logic [3:0] r,
                          input int done_cycle, input bit timeout);
    int rise;
    int tx;
    push_exp(which, EV_MEM, 1, r, 1'b0, 1'b0, 8'd0, 1'b0);
    for (int k = 0; k < n_steps; k++) begin
      rise = 2 + k * PERIOD_CYC + 4;
      push_exp(which, EV_RISE, rise, r, 1'b0, 1'b0, 8'(k), 1'b0);
      if (k == n_steps - 1)
        push_exp(which, EV_FALL, rise + 12, r, 1'b1, 1'b0, 8'(k), 1'b1);
      else
        push_exp(which, EV_FALL, rise + 12, r, 1'b0, 1'b0, 8'(k + 1), 1'b0);
    end
    tx = 2 + n_steps * PERIOD_CYC;
    push_exp(which, EV_TX, tx, r, 1'b1, 1'b0, 8'(n_steps - 1), 1'b1);
    push_exp(which, EV_DONE, timeout ? tx + 1 + 20 : done_cycle + 1, r, 1'b1,
             timeout, 8'(n_steps - 1), 1'b1);
  endtask

  task automatic handle_event(input int which, input ev_kind_t kind, input int rel,
                              input logic [3:0] res, input logic rv, input logic err,
                              input logic [7:0] step);
    exp_t  e;
    string tag;
    tag = $sformatf("dut%0d_%s@%0d", which, kind.name(), rel);
    if ((which == 0 && q_a.size() == 0) || (which == 1 && q_b.size() == 0)) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s unexpected event actual=present required=none", tag);
      return;
    end
    if (which == 0) e = q_a.pop_front();
    else e = q_b.pop_front();
    check_output({tag, "_kind"}, kind, e.kind);
    check_output({tag, "_cycle"}, rel, e.cycle);
    check_output({tag, "_result_valid"}, rv, e.result_valid);
    check_output({tag, "_tx_err"}, err, e.tx_err);
    check_output({tag, "_step_idx"}, step, e.step_idx);
    if (e.check_result) check_output({tag, "_result"}, res, e.result);
  endtask

  always @(negedge CLK) begin
    if (mon_en) begin
      if (mem_clk_a === 1'b1) handle_event(0, EV_MEM, cyc_now - base_a, result_a, rv_a, err_a, step_a);
      if (glt_a === 1'b1 && !prev_glt_a) handle_event(0, EV_RISE, cyc_now - base_a, result_a, rv_a, err_a, step_a);
      if (glt_a === 1'b0 && prev_glt_a) handle_event(0, EV_FALL, cyc_now - base_a, result_a, rv_a, err_a, step_a);
      if (tx_start_a === 1'b1) handle_event(0, EV_TX, cyc_now - base_a, result_a, rv_a, err_a, step_a);
      if (done_a === 1'b1) handle_event(0, EV_DONE, cyc_now - base_a, result_a, rv_a, err_a, step_a);
      if (mem_clk_b === 1'b1) handle_event(1, EV_MEM, cyc_now - base_b, result_b, rv_b, err_b, step_b);
      if (glt_b === 1'b1 && !prev_glt_b) handle_event(1, EV_RISE, cyc_now - base_b, result_b, rv_b, err_b, step_b);
      if (glt_b === 1'b0 && prev_glt_b) handle_event(1, EV_FALL, cyc_now - base_b, result_b, rv_b, err_b, step_b);
      if (tx_start_b === 1'b1) handle_event(1, EV_TX, cyc_now - base_b, result_b, rv_b, err_b, step_b);
      if (done_b === 1'b1) handle_event(1, EV_DONE, cyc_now - base_b, result_b, rv_b, err_b, step_b);
    end
    prev_glt_a = (glt_a === 1'b1);
    prev_glt_b = (glt_b === 1'b1);
  end

  task automatic check_zero(input int which, input string tag);
    if (which == 0) begin
      check_output({tag, "_a_Memory_CLK"}, mem_clk_a, 0);
      check_output({tag, "_a_global_leak_time"}, glt_a, 0);
      check_output({tag, "_a_tx_start"}, tx_start_a, 0);
      check_output({tag, "_a_result"}, result_a, 0);
      check_output({tag, "_a_result_valid"}, rv_a, 0);
      check_output({tag, "_a_tx_err"}, err_a, 0);
      check_output({tag, "_a_done"}, done_a, 0);
      check_output({tag, "_a_busy"}, busy_a, 0);
      check_output({tag, "_a_step_idx"}, step_a, 0);
    end else begin
      check_output({tag, "_b_Memory_CLK"}, mem_clk_b, 0);
      check_output({tag, "_b_global_leak_time"}, glt_b, 0);
      check_output({tag, "_b_tx_start"}, tx_start_b, 0);
      check_output({tag, "_b_result"}, result_b, 0);
      check_output({tag, "_b_result_valid"}, rv_b, 0);
      check_output({tag, "_b_tx_err"}, err_b, 0);
      check_output({tag, "_b_done"}, done_b, 0);
      check_output({tag, "_b_busy"}, busy_b, 0);
      check_output({tag, "_b_step_idx"}, step_b, 0);
    end
  endtask

  // Issues one start, then drives per-cycle inputs on the spec's relative
  // timeline; a negative cycle argument disables that input.
  task automatic apply_stimulus(input int which, input logic [3:0] r, input int done_cycle,
                                input int abort_cycle, input int reset_cycle,
                                input bit ignore_starts, input int end_cycle);
    int rel;
    @(negedge CLK);
    if (which == 0) begin result_num_a = r; start_a = 1'b1; end
    else begin result_num_b = r; start_b = 1'b1; end
    @(posedge CLK);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    if (which == 0) base_a = cyc_now - 1;
    else base_b = cyc_now - 1;
    rel = 1;
    while (rel < end_cycle) begin
      @(negedge CLK);
      rel = cyc_now - ((which == 0) ? base_a : base_b);
      if (which == 0) begin
        udp_done_a = (rel == done_cycle);
        abort_a    = (rel == abort_cycle);
        rst_a      = (rel == reset_cycle);
        start_a    = ignore_starts && (rel == 10 || rel == 30);
      end else begin
        udp_done_b = (rel == done_cycle);
        abort_b    = (rel == abort_cycle);
        rst_b      = (rel == reset_cycle);
        start_b    = ignore_starts && (rel == 10 || rel == 30);
      end
      if (abort_cycle >= 0 && rel == abort_cycle + 1) begin
        check_output("abort_busy", busy_a, 0);
        check_output("abort_global_leak_time", glt_a, 0);
        check_output("abort_result_valid", rv_a, 0);
        check_output("abort_tx_start", tx_start_a, 0);
        check_output("abort_done", done_a, 0);
      end
      if (reset_cycle >= 0 && rel == reset_cycle + 1) check_zero(which, "mid_reset");
    end
    if (which == 0) check_output("dut0_queue_empty", q_a.size(), 0);
    else check_output("dut1_queue_empty", q_b.size(), 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_zero(0, "reset");
    check_zero(1, "reset");
    rst_a  = 1'b0;
    rst_b  = 1'b0;
    mon_en = 1'b1;

    $display("[TB] nominal pass, class 7, transfer done at 40");
    push_run(0, 2, 4'd7, 40, 1'b0);
    apply_stimulus(0, 4'd7, 40, -1, -1, 1'b0, 45);
    check_output("nominal_hold_result", result_a, 7);
    check_output("nominal_hold_valid", rv_a, 1);
    check_output("nominal_idle_busy", busy_a, 0);

    $display("[TB] transfer timeout, class 3");
    push_run(0, 2, 4'd3, -1, 1'b1);
    apply_stimulus(0, 4'd3, -1, -1, -1, 1'b0, 58);
    check_output("timeout_err_sticky", err_a, 1);
    check_output("timeout_hold_result", result_a, 3);

    $display("[TB] starts while busy are ignored, class 5");
    push_run(0, 2, 4'd5, 40, 1'b0);
    apply_stimulus(0, 4'd5, 40, -1, -1, 1'b1, 45);

    $display("[TB] abort in final leak window");
    push_exp(0, EV_MEM, 1, 4'd0, 1'b0, 1'b0, 8'd0, 1'b0);
    push_exp(0, EV_RISE, 6, 4'd0, 1'b0, 1'b0, 8'd0, 1'b0);
    push_exp(0, EV_FALL, 18, 4'd0, 1'b0, 1'b0, 8'd1, 1'b0);
    push_exp(0, EV_RISE, 22, 4'd0, 1'b0, 1'b0, 8'd1, 1'b0);
    push_exp(0, EV_FALL, 26, 4'd0, 1'b0, 1'b0, 8'd1, 1'b0);
    apply_stimulus(0, 4'd9, -1, 25, -1, 1'b0, 60);

    $display("[TB] reset in first leak window, then a fresh sample");
    push_exp(0, EV_MEM, 1, 4'd0, 1'b0, 1'b0, 8'd0, 1'b0);
    push_exp(0, EV_RISE, 6, 4'd0, 1'b0, 1'b0, 8'd0, 1'b0);
    push_exp(0, EV_FALL, 16, 4'd0, 1'b0, 1'b0, 8'd0, 1'b1);
    apply_stimulus(0, 4'd2, -1, -1, 15, 1'b0, 20);
    push_run(0, 2, 4'd12, 40, 1'b0);
    apply_stimulus(0, 4'd12, 40, -1, -1, 1'b0, 45);

    $display("[TB] single timestep instance");
    push_run(1, 1, 4'd4, 22, 1'b0);
    apply_stimulus(1, 4'd4, 22, -1, -1, 1'b0, 30);
    check_output("single_step_idx", step_b, 0);
    check_output("single_result", result_b, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inference_scheduler.md
# inference_scheduler

Sequencer for one spike-count classification pass. It clears the output-neuron spike counters, then alternates integrate and leak windows for a fixed number of timesteps. After the final window it captures the argmax class and requests one UDP transfer of the class-count bytes, waiting for completion or a timeout. It sits between the host/UDP control logic and the spike counter/argmax datapath, and drives that datapath's clear and leak-window inputs.

## Interface
- NUM_STEPS, 16: timesteps per sample; range 1..255.
- STEP_CYCLES, 1000: integrate cycles per timestep; range 1..65535.
- LEAK_CYCLES, 12: leak-window cycles per timestep; minimum 12, so the 11-cycle argmax scan completes inside each window.
- TX_TIMEOUT, 65535: maximum cycles to wait for transfer completion.

- CLK  in  1  system clock.
- RST_sync  in  1  reset; one clock, synchronous, active-high.
- start  in  1  one-cycle request to process a sample; honoured only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE from any state.
- result_num  in  4  argmax class from the counter datapath.
- udp_tx_done_source  in  1  one-cycle pulse when the UDP frame is sent.
- Memory_CLK  out  1  counter clear, high for exactly 1 cycle per sample.
- global_leak_time  out  1  leak window; freezes the counters and triggers argmax.
- tx_start  out  1  one-cycle UDP transfer request.
- result  out  4  latched class.
- result_valid  out  1  result holds the current sample's class.
- tx_err  out  1  last transfer timed out; sticky until the next accepted start.
- done  out  1  one-cycle end-of-sample pulse.
- busy  out  1  high whenever state is not IDLE.
- step_idx  out  8  current timestep, 0-based.

## Operation
- States: IDLE, CLEAR, INTEGRATE, LEAK, TX_REQ, TX_WAIT, DONE.
- All outputs are registered and decoded from state. Reset values are all 0, state is IDLE, and internal counters are 0.
- IDLE:
  - start=1 and abort=0 → CLEAR.
  - On accept: clear result_valid, tx_err, step_idx.
- CLEAR: Memory_CLK=1 for 1 cycle → INTEGRATE.
- INTEGRATE: lasts STEP_CYCLES cycles, with global_leak_time=0 → LEAK.
- LEAK:
  - Lasts LEAK_CYCLES cycles, with global_leak_time=1.
  - The window is continuous, with no dropout inside it.
  - At its last cycle:
    - If step_idx<NUM_STEPS-1: step_idx+1, → INTEGRATE.
    - Otherwise: result←result_num, result_valid←1, → TX_REQ.
- TX_REQ: tx_start=1 for 1 cycle → TX_WAIT.
- TX_WAIT:
  - udp_tx_done_source=1 → DONE.
  - After TX_TIMEOUT cycles with no done: tx_err←1, → DONE.
  - A done pulse in the same cycle as the timeout counts as success.
- DONE: done=1 for 1 cycle → IDLE.
- result and result_valid hold in IDLE until the next accepted start.
- abort=1, any state except IDLE:
  - Next cycle is IDLE; global_leak_time and tx_start drop.
  - No done pulse; result_valid=0.
  - Abort wins over a simultaneous start or done.
- start outside IDLE is ignored and not queued.
- Reset mid-sample: same outcome as abort, but every output is forced to its reset value.
- The phase counter reloads on every state entry. Its width is ceil(log2(max(STEP_CYCLES, LEAK_CYCLES, TX_TIMEOUT)+1)).

## Timing
- Take start sampled at edge 0:
  - CLEAR occupies cycle 1.
  - Timestep k INTEGRATE starts at cycle 2+k·(STEP_CYCLES+LEAK_CYCLES).
  - The final LEAK ends at cycle T=1+NUM_STEPS·(STEP_CYCLES+LEAK_CYCLES).
  - result_valid and tx_start are high in cycle T+1.
- The datapath updates result_num 11 cycles after the leak rise. Latching at the last leak cycle therefore needs LEAK_CYCLES≥12.
- done comes 1 cycle after the cycle in which udp_tx_done_source is sampled high.

## Structure
- The shared package holds:
  - the state enum (3 bits);
  - ARGMAX_LAT=11;
  - the MIN_LEAK_CYCLES=12 constant, with an elaboration check on LEAK_CYCLES.
- One sub-module, phase_timer: a loadable down-counter with a load input, a load value, and an expired flag that is high when the count is 0. It is shared by the INTEGRATE, LEAK and TX_WAIT phases.

## Test plan
- Test parameters are NUM_STEPS=2, STEP_CYCLES=4, LEAK_CYCLES=12, TX_TIMEOUT=20.
- Nominal pass with result_num=7 and a done pulse at cycle 40:
  - Memory_CLK high at cycle 1.
  - global_leak_time high at 6–17 and 22–33.
  - result=7 and result_valid=1 from cycle 34; tx_start at 34.
  - done at 41.
- Timeout, with no udp_tx_done_source:
  - tx_err=1 and done 20 cycles after TX_WAIT entry.
  - tx_err clears on the next start.
- Abort at cycle 25 (mid final LEAK):
  - IDLE at 26, global_leak_time=0, result_valid=0.
  - No done and no tx_start.
- start pulses at cycles 10 and 30 while busy are ignored; the timing matches the nominal run.
- RST_sync at cycle 15 → all outputs 0 at cycle 16; a later start gives the nominal timeline relative to itself.
- NUM_STEPS=1 → a single integrate/leak window, and step_idx stays 0.
